// File: rtl/opl3_host_arbiter_if.sv
// Requester-side and OPL3 host-bus signals of the host arbiter, grouped for port connection.
// slave = arbiter view; master = requesters plus OPL3 core view.
interface opl3_host_arbiter_if;
  logic [1:0]      req;
  logic [1:0]      req_bank;
  logic [1:0][7:0] req_reg;
  logic [1:0][7:0] req_data;
  logic [1:0]      done;
  logic            err;
  logic            busy;
  logic            opl_cs_n;
  logic            opl_wr_n;
  logic            opl_rd_n;
  logic [1:0]      opl_address;
  logic [7:0]      opl_din;
  logic            opl_ack_host_wr;

  modport slave (
    input  req, req_bank, req_reg, req_data, opl_ack_host_wr,
    output done, err, busy, opl_cs_n, opl_wr_n, opl_rd_n, opl_address, opl_din
  );

  modport master (
    output req, req_bank, req_reg, req_data, opl_ack_host_wr,
    input  done, err, busy, opl_cs_n, opl_wr_n, opl_rd_n, opl_address, opl_din
  );
endinterface

// File: rtl/opl3_host_arbiter.sv
// Round-robin arbiter turning two requesters' register writes into four-phase OPL3 host-bus cycles.
// Grant 1 cycle after req; requesters are held off by level req until done; the core paces via ack or timeout.
module opl3_host_arbiter #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input logic                clk,
  input logic                ic_n,
  opl3_host_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR_WR  = 3'd1;
  localparam logic [2:0] S_ADDR_REL = 3'd2;
  localparam logic [2:0] S_DATA_WR  = 3'd3;
  localparam logic [2:0] S_DATA_REL = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [15:0] TIMEOUT  = 16'(ACK_TIMEOUT);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES);

  logic [2:0]  state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        last_gnt, last_gnt_nxt;
  logic        lat_bank, bank_nxt;
  logic [7:0]  lat_reg, reg_nxt;
  logic [7:0]  lat_data, data_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic        timed_out;
  logic        finish;
  logic        abort;

  logic        cs_n_q, cs_n_nxt;
  logic        wr_n_q, wr_n_nxt;
  logic        rd_n_q;
  logic [1:0]  addr_q, addr_nxt;
  logic [7:0]  din_q, din_nxt;
  logic [1:0]  done_q, done_nxt;
  logic        err_q, err_nxt;
  logic        busy_q, busy_nxt;

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    bank_nxt     = lat_bank;
    reg_nxt      = lat_reg;
    data_nxt     = lat_data;
    wait_cnt_nxt = wait_cnt + 16'd1;
    gap_cnt_nxt  = gap_cnt;
    done_nxt     = 2'b00;
    err_nxt      = 1'b0;
    timed_out    = (wait_cnt == TIMEOUT);
    finish       = 1'b0;
    abort        = 1'b0;

    case (state)
      S_IDLE: begin
        wait_cnt_nxt = 16'd0;
        if (bus.req != 2'b00) begin
          // Contention goes to whoever was not served last; a lone requester always wins.
          if (bus.req == 2'b11) gnt_nxt = ~last_gnt;
          else                  gnt_nxt = bus.req[1];
          last_gnt_nxt = gnt_nxt;
          bank_nxt     = bus.req_bank[gnt_nxt];
          reg_nxt      = bus.req_reg[gnt_nxt];
          data_nxt     = bus.req_data[gnt_nxt];
          state_nxt    = S_ADDR_WR;
          wait_cnt_nxt = 16'd1;
        end
      end
      S_ADDR_WR: begin
        if (bus.opl_ack_host_wr) begin
          state_nxt    = S_ADDR_REL;
          wait_cnt_nxt = 16'd1;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      S_ADDR_REL: begin
        if (!bus.opl_ack_host_wr) begin
          state_nxt    = S_DATA_WR;
          wait_cnt_nxt = 16'd1;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      S_DATA_WR: begin
        if (bus.opl_ack_host_wr) begin
          state_nxt    = S_DATA_REL;
          wait_cnt_nxt = 16'd1;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      S_DATA_REL: begin
        if (!bus.opl_ack_host_wr) finish = 1'b1;
        else if (timed_out)       abort  = 1'b1;
      end
      S_GAP: begin
        wait_cnt_nxt = 16'd0;
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = S_IDLE;
          gap_cnt_nxt = 8'd0;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        wait_cnt_nxt = 16'd0;
      end
    endcase

    // Normal completion and timeout both end in GAP; err distinguishes them.
    if (finish || abort) begin
      state_nxt    = S_GAP;
      gap_cnt_nxt  = 8'd1;
      wait_cnt_nxt = 16'd0;
      done_nxt     = gnt ? 2'b10 : 2'b01;
      err_nxt      = abort;
    end
  end

  // Outputs are decoded from the next state so the registered strobes line up with the state register.
  always_comb begin
    cs_n_nxt = 1'b1;
    wr_n_nxt = 1'b1;
    addr_nxt = 2'b00;
    din_nxt  = 8'h00;
    busy_nxt = (state_nxt != S_IDLE);
    case (state_nxt)
      S_ADDR_WR: begin
        cs_n_nxt = 1'b0;
        wr_n_nxt = 1'b0;
        addr_nxt = {bank_nxt, 1'b0};
        din_nxt  = reg_nxt;
      end
      S_ADDR_REL: begin
        addr_nxt = {bank_nxt, 1'b0};
        din_nxt  = reg_nxt;
      end
      S_DATA_WR: begin
        cs_n_nxt = 1'b0;
        wr_n_nxt = 1'b0;
        addr_nxt = {bank_nxt, 1'b1};
        din_nxt  = data_nxt;
      end
      S_DATA_REL: begin
        addr_nxt = {bank_nxt, 1'b1};
        din_nxt  = data_nxt;
      end
      default: begin
        cs_n_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state    <= S_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      lat_bank <= 1'b0;
      lat_reg  <= 8'h00;
      lat_data <= 8'h00;
      wait_cnt <= 16'd0;
      gap_cnt  <= 8'd0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      addr_q   <= 2'b00;
      din_q    <= 8'h00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      lat_bank <= bank_nxt;
      lat_reg  <= reg_nxt;
      lat_data <= data_nxt;
      wait_cnt <= wait_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      cs_n_q   <= cs_n_nxt;
      wr_n_q   <= wr_n_nxt;
      rd_n_q   <= 1'b1;
      addr_q   <= addr_nxt;
      din_q    <= din_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign bus.opl_cs_n    = cs_n_q;
  assign bus.opl_wr_n    = wr_n_q;
  assign bus.opl_rd_n    = rd_n_q;
  assign bus.opl_address = addr_q;
  assign bus.opl_din     = din_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_opl3_host_arbiter.sv
// Scoreboard bench for opl3_host_arbiter: directed transfers, contention, timeout, mid-transfer drop, reset, short gap.
module tb_opl3_host_arbiter;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] din;
  } wr_t;

  typedef struct packed {
    logic idx;
    logic err;
  } dn_t;

  logic clk;
  logic ic_n;
  bit   ack_en;
  int   low_cnt;
  int   rel_cnt;
  int   n_tests;
  int   n_fail;

  wr_t exp_wr[$];
  dn_t exp_done[$];

  opl3_host_arbiter_if bus ();
  opl3_host_arbiter_if bus1 ();

  opl3_host_arbiter dut (
    .clk  (clk),
    .ic_n (ic_n),
    .bus  (bus)
  );

  opl3_host_arbiter #(.GAP_CYCLES(1)) dut_g1 (
    .clk  (clk),
    .ic_n (ic_n),
    .bus  (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Core model: ack two cycles into each strobe, released two cycles after the strobe drops.
  initial begin
    bus.opl_ack_host_wr = 1'b0;
    low_cnt = 0;
    rel_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.opl_cs_n) begin
        rel_cnt = 0;
        if (ack_en) begin
          low_cnt++;
          if (low_cnt >= 2) bus.opl_ack_host_wr = 1'b1;
        end
      end else begin
        low_cnt = 0;
        if (bus.opl_ack_host_wr) begin
          rel_cnt++;
          if (rel_cnt >= 2) begin
            bus.opl_ack_host_wr = 1'b0;
            rel_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    bus1.opl_ack_host_wr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus1.opl_ack_host_wr = !bus1.opl_cs_n;
    end
  end

  // Monitor: every strobe start and every done pulse is matched against the scoreboard queues.
  initial begin
    logic prev_cs;
    wr_t  w;
    dn_t  d;
    prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_cs && !bus.opl_cs_n) begin
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bus_write_unexpected: got addr=%b din=0x%02h, required no write", bus.opl_address, bus.opl_din);
        end else begin
          w = exp_wr.pop_front();
          chk("bus_addr", 32'(bus.opl_address), 32'(w.addr));
          chk("bus_din", 32'(bus.opl_din), 32'(w.din));
          chk("bus_wr_n", 32'(bus.opl_wr_n), 32'd0);
          chk("bus_rd_n", 32'(bus.opl_rd_n), 32'd1);
          chk("bus_busy", 32'(bus.busy), 32'd1);
        end
      end
      prev_cs = bus.opl_cs_n;
      if (bus.err && bus.done == 2'b00) begin
        n_tests++;
        n_fail++;
        $display("FAIL err_without_done: got err=1 done=00, required done with err");
      end
      if (bus.done != 2'b00) begin
        chk("done_not_both", 32'(bus.done == 2'b11), 32'd0);
        if (exp_done.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got done=%b err=%b, required none", bus.done, bus.err);
        end else begin
          d = exp_done.pop_front();
          chk("done_idx", 32'(bus.done), d.idx ? 32'd2 : 32'd1);
          chk("done_err", 32'(bus.err), 32'(d.err));
        end
      end
    end
  end

  task automatic wait_done(input int idx, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.done[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_cs(input logic v, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.opl_cs_n == v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic push_xfer(input logic bank, input logic [7:0] r, input logic [7:0] d);
    exp_wr.push_back(wr_t'{{bank, 1'b0}, r});
    exp_wr.push_back(wr_t'{{bank, 1'b1}, d});
  endtask

  task automatic do_xfer(input int idx, input logic bank, input logic [7:0] r, input logic [7:0] d, input string name);
    bus.req_bank[idx] = bank;
    bus.req_reg[idx]  = r;
    bus.req_data[idx] = d;
    push_xfer(bank, r, d);
    exp_done.push_back(dn_t'{idx[0], 1'b0});
    bus.req[idx] = 1'b1;
    wait_done(idx, name);
    bus.req[idx] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 ic_n = 1'b0;
    repeat (2) @(negedge clk);
    ic_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    bit ok;
    n_tests = 0;
    n_fail  = 0;
    ack_en  = 1'b1;
    bus.req = 2'b00;   bus.req_bank = 2'b00;  bus.req_reg = '0;  bus.req_data = '0;
    bus1.req = 2'b00;  bus1.req_bank = 2'b00; bus1.req_reg = '0; bus1.req_data = '0;
    ic_n = 1'b1;
    #1 ic_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(bus.opl_cs_n), 32'd1);
    chk("rst_wr_n", 32'(bus.opl_wr_n), 32'd1);
    chk("rst_rd_n", 32'(bus.opl_rd_n), 32'd1);
    chk("rst_addr", 32'(bus.opl_address), 32'd0);
    chk("rst_din", 32'(bus.opl_din), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    ic_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write: bank 1, register 0x05, data 0x01; busy drops exactly 4 gap cycles after done.
    do_xfer(0, 1'b1, 8'h05, 8'h01, "basic_done");
    repeat (3) @(negedge clk);
    chk("basic_busy_in_gap", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("basic_busy_after_gap", 32'(bus.busy), 32'd0);
    chk("basic_din_idle", 32'(bus.opl_din), 32'd0);

    // Contention from reset: grants alternate 0,1,0,1.
    pulse_reset();
    bus.req_bank = 2'b10;
    bus.req_reg[0] = 8'h01;  bus.req_data[0] = 8'hA1;
    bus.req_reg[1] = 8'h02;  bus.req_data[1] = 8'hB2;
    for (int k = 0; k < 2; k++) begin
      push_xfer(1'b0, 8'h01, 8'hA1);
      exp_done.push_back(dn_t'{1'b0, 1'b0});
      push_xfer(1'b1, 8'h02, 8'hB2);
      exp_done.push_back(dn_t'{1'b1, 1'b0});
    end
    bus.req = 2'b11;
    wait_done(0, "rr_done0");
    n = 0;
    while (bus.opl_cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rr_done_to_next_strobe", 32'(n), 32'd5);
    wait_done(1, "rr_done1");
    wait_done(0, "rr_done2");
    wait_done(1, "rr_done3");
    bus.req = 2'b00;
    repeat (8) @(negedge clk);

    // Core never acks: strobe held 255 cycles, then done with err.
    ack_en = 1'b0;
    bus.req_bank[0] = 1'b0;  bus.req_reg[0] = 8'h20;  bus.req_data[0] = 8'h33;
    exp_wr.push_back(wr_t'{2'b00, 8'h20});
    exp_done.push_back(dn_t'{1'b0, 1'b1});
    bus.req[0] = 1'b1;
    wait_cs(1'b0, "to_strobe_start");
    n = 0;
    while (!bus.opl_cs_n && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("to_strobe_len", 32'(n), 32'd255);
    chk("to_done_with_release", 32'(bus.done[0]), 32'd1);
    chk("to_wr_n_released", 32'(bus.opl_wr_n), 32'd1);
    bus.req[0] = 1'b0;
    ack_en = 1'b1;
    do_xfer(1, 1'b1, 8'hA0, 8'h44, "to_next_done");
    repeat (6) @(negedge clk);

    // Requester 1 drops out during ADDR_REL; latched data still goes out.
    bus.req_bank[1] = 1'b0;  bus.req_reg[1] = 8'h40;  bus.req_data[1] = 8'h7E;
    push_xfer(1'b0, 8'h40, 8'h7E);
    exp_done.push_back(dn_t'{1'b1, 1'b0});
    bus.req[1] = 1'b1;
    wait_cs(1'b0, "drop_addr_strobe");
    wait_cs(1'b1, "drop_addr_release");
    bus.req[1] = 1'b0;
    bus.req_reg[1] = 8'h00;
    bus.req_data[1] = 8'hFF;
    wait_done(1, "drop_done");
    repeat (6) @(negedge clk);

    // Reset during DATA_WR: strobes release immediately and no done is issued.
    bus.req_bank[0] = 1'b0;  bus.req_reg[0] = 8'h11;  bus.req_data[0] = 8'h22;
    push_xfer(1'b0, 8'h11, 8'h22);
    bus.req[0] = 1'b1;
    wait_cs(1'b0, "rstx_addr_strobe");
    wait_cs(1'b1, "rstx_addr_release");
    wait_cs(1'b0, "rstx_data_strobe");
    #2 ic_n = 1'b0;
    #1;
    chk("rstx_cs_n", 32'(bus.opl_cs_n), 32'd1);
    chk("rstx_wr_n", 32'(bus.opl_wr_n), 32'd1);
    chk("rstx_addr", 32'(bus.opl_address), 32'd0);
    chk("rstx_din", 32'(bus.opl_din), 32'd0);
    chk("rstx_busy", 32'(bus.busy), 32'd0);
    chk("rstx_done", 32'(bus.done), 32'd0);
    bus.req[0] = 1'b0;
    repeat (3) @(negedge clk);
    ic_n = 1'b1;
    repeat (4) @(negedge clk);
    do_xfer(0, 1'b1, 8'h33, 8'h44, "rstx_post_done");
    repeat (8) @(negedge clk);

    // GAP_CYCLES=1 instance: one GAP cycle and one IDLE cycle between back-to-back transfers.
    bus1.req_bank[0] = 1'b0;  bus1.req_reg[0] = 8'h0A;  bus1.req_data[0] = 8'h5A;
    bus1.req[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus1.done[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("g1_done1", 32'(ok), 32'd1);
    chk("g1_err", 32'(bus1.err), 32'd0);
    chk("g1_busy_gap", 32'(bus1.busy), 32'd1);
    @(negedge clk);
    chk("g1_busy_idle", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    chk("g1_regrant_cs_n", 32'(bus1.opl_cs_n), 32'd0);
    chk("g1_regrant_addr", 32'(bus1.opl_address), 32'd0);
    chk("g1_regrant_din", 32'(bus1.opl_din), 32'h0A);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus1.done[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("g1_done2", 32'(ok), 32'd1);
    bus1.req[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("g1_busy_end", 32'(bus1.busy), 32'd0);

    chk("sb_writes_left", 32'(exp_wr.size()), 32'd0);
    chk("sb_dones_left", 32'(exp_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
